match_collector: RTL
====================

Name: match_collector

Overview:
- Sits directly downstream of the serial pattern scanner. The scanner walks a 32-bit word MSB-first, one bit per cycle, and raises a 1-bit hit strobe whenever the last PAT_LEN bits equal the pattern.
- This block counts those hits across one full word scan and records the first and last hit positions plus a per-position hit map.
- It presents the result to the LED/display stage with a valid/ack handshake.

Parameters:
- WIDTH, 32, bits per scanned word (number of bit-cycles per scan)
- PAT_LEN, 4, pattern length; hits at index < PAT_LEN-1 are impossible and are masked
- POS_W, 5, width of a bit index, equal to clog2(WIDTH)
- CNT_W, 6, width of the match counter, equal to clog2(WIDTH+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- scan_start  in  1  one-cycle pulse: a new word scan begins next bit_valid
- bit_valid  in  1  scanner consumed one bit this cycle
- hit  in  1  scanner match strobe; qualified by bit_valid
- result_ack  in  1  consumer accepts result
- busy  out  1  high in SCAN
- result_valid  out  1  result registers stable and valid
- match_count  out  CNT_W  number of accepted hits in last scan
- first_pos  out  POS_W  bit index of first accepted hit
- last_pos  out  POS_W  bit index of last accepted hit
- hit_map  out  WIDTH  bit i set when hit accepted at index i
- no_match  out  1  result_valid and match_count==0

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE.
  - All outputs 0: busy, result_valid, match_count, first_pos, last_pos, hit_map, no_match. Internal idx=0.
  - Reset mid-SCAN or in DONE aborts without producing a result.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - scan_start=1 -> SCAN next cycle; idx, match_count, hit_map, first_pos and last_pos cleared on the same edge.
  - bit_valid and hit are ignored in IDLE.
- SCAN:
  - busy=1.
  - Each cycle with bit_valid=1: the current idx is the index of the bit consumed. A hit is accepted iff hit=1 and idx >= PAT_LEN-1.
  - On an accepted hit:
    - match_count += 1
    - hit_map[idx] <= 1
    - last_pos <= idx
    - first_pos <= idx, only if match_count was 0
  - After each bit_valid, idx increments.
  - When bit_valid=1 and idx==WIDTH-1, that bit is processed normally, then the next state is DONE and idx returns to 0.
  - bit_valid=0: no change; hit is ignored.
  - scan_start=1 in SCAN restarts the scan: all accumulators cleared, idx=0, remain in SCAN. restart takes priority over a same-cycle bit_valid, whose bit is discarded.
- DONE:
  - result_valid=1; outputs held stable.
  - no_match = (match_count==0).
  - result_ack=1 -> IDLE next cycle. result_valid drops; data outputs keep their values until the next scan_start clears them.
  - scan_start in DONE without result_ack is ignored.
  - scan_start together with result_ack -> go directly to SCAN with accumulators cleared; result_valid drops.
- Latency: result_valid rises on the edge that processes bit WIDTH-1, i.e. 1 cycle after the final bit_valid is sampled.
- Width rules:
  - match_count cannot overflow: the maximum is WIDTH-PAT_LEN+1 < 2^CNT_W.
  - idx never exceeds WIDTH-1.
- Without result_ack, DONE is held indefinitely. bit_valid in DONE is ignored, and no data is lost internally; backpressure is the upstream stage's responsibility.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), the defaults WIDTH=32 and PAT_LEN=4, and the derived POS_W/CNT_W constants. The scanner, this block and the display stage all use them.
- One natural sub-module: match_bit_index, the idx counter with wrap/last-bit flag (inputs clear, step; outputs idx, is_last). All accumulation and FSM logic stays in match_collector.

Test Plan:
- Reset:
  - Stimulus: assert rst for 10 cycles mid-SCAN, with scan_start and hit toggling.
  - Response: all outputs 0 every cycle while rst=1; IDLE afterwards.
- Nominal word:
  - Stimulus: scan_start, then 32 consecutive bit_valid with hit at idx 6, 18 and 31 (the hits for D=32'hEDEADCF6, P=4'b0110).
  - Response: result_valid 1 cycle after the last bit; match_count=3, first_pos=6, last_pos=31, hit_map=32'h8004_0040, no_match=0.
- Masking and gaps:
  - Stimulus: hit=1 at idx 0-2 plus hit pulses with bit_valid=0; bit_valid idle for random gaps.
  - Response: those hits are ignored; with no other hits, match_count=0, no_match=1, hit_map=0.
- All-ones pattern:
  - Stimulus: hit=1 on every bit.
  - Response: match_count=29, first_pos=3, last_pos=31, hit_map=32'hFFFF_FFF8.
- Restart:
  - Stimulus: scan_start at idx 10 after 2 hits, then a full clean scan with a single hit at idx 20.
  - Response: match_count=1, first_pos=last_pos=20.
- Handshake:
  - Stimulus: hold result_ack=0 for 50 cycles with scan_start pulses, then result_ack together with scan_start.
  - Response: outputs stable and scan_start ignored while waiting; on the final pulse, goes directly to SCAN with busy=1 and result_valid=0 next cycle.

Source files
------------

// File: rtl/match_collector_pkg.sv
// ============================================================================
// Module      : match_collector_pkg
// Description : Shared FSM encoding and default sizing for the scanner,
//               the match collector and the display stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package match_collector_pkg;

  // Collector FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default word/pattern geometry
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_POS_W   = $clog2(DEF_WIDTH);
  localparam int DEF_CNT_W   = $clog2(DEF_WIDTH + 1);

endpackage

`default_nettype wire

// File: rtl/match_bit_index.sv
// ============================================================================
// Module      : match_bit_index
// Description : Bit-position counter for one word scan; wraps to 0 after the
//               last bit and flags when the current position is the last one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_bit_index
  import match_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int POS_W = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [POS_W-1:0] idx,
  output logic             is_last
);

  localparam logic [POS_W-1:0] C_LAST = POS_W'(WIDTH - 1);

  logic [POS_W-1:0] r_idx;

  assign idx     = r_idx;
  assign is_last = (r_idx == C_LAST);

  // Clear dominates step; stepping past the last bit wraps to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (step) begin
      r_idx <= is_last ? '0 : r_idx + POS_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/match_collector.sv
// ============================================================================
// Module      : match_collector
// Description : Accumulates scanner hit strobes over one word scan (count,
//               first/last hit position, per-position hit map) and offers the
//               result to the display stage through a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_collector
  import match_collector_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int POS_W   = DEF_POS_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_start,
  input  logic             bit_valid,
  input  logic             hit,
  input  logic             result_ack,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] match_count,
  output logic [POS_W-1:0] first_pos,
  output logic [POS_W-1:0] last_pos,
  output logic [WIDTH-1:0] hit_map,
  output logic             no_match
);

  // Lowest position at which a full pattern can have been seen
  localparam logic [POS_W-1:0] C_MIN_IDX = POS_W'(PAT_LEN - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [POS_W-1:0] r_first;
  logic [POS_W-1:0] r_last;
  logic [WIDTH-1:0] r_map;

  logic [POS_W-1:0] w_idx;
  logic             w_is_last;
  logic             w_clear;
  logic             w_step;
  logic             w_accept;

  // A new scan begins from IDLE or SCAN on scan_start, or from DONE only
  // when the result is acknowledged in the same cycle.
  assign w_clear  = scan_start &&
                    ((r_state == ST_IDLE) || (r_state == ST_SCAN) ||
                     ((r_state == ST_DONE) && result_ack));
  // A restart discards any bit presented in the same cycle
  assign w_step   = (r_state == ST_SCAN) && bit_valid && !scan_start;
  assign w_accept = w_step && hit && (w_idx >= C_MIN_IDX);

  match_bit_index #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_bit_index (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .step    (w_step),
    .idx     (w_idx),
    .is_last (w_is_last)
  );

  // Scan control: IDLE -> SCAN -> DONE -> IDLE (or straight back to SCAN)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (scan_start) r_state <= ST_SCAN;
        ST_SCAN: if (w_step && w_is_last) r_state <= ST_DONE;
        ST_DONE: begin
          if (result_ack) r_state <= scan_start ? ST_SCAN : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result accumulators; held between scans until the next start clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_map   <= '0;
    end else if (w_clear) begin
      r_count <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_map   <= '0;
    end else if (w_accept) begin
      r_count        <= r_count + CNT_W'(1);
      r_last         <= w_idx;
      r_map[w_idx]   <= 1'b1;
      if (r_count == '0) begin
        r_first <= w_idx;
      end
    end
  end

  assign busy         = (r_state == ST_SCAN);
  assign result_valid = (r_state == ST_DONE);
  assign no_match     = result_valid && (r_count == '0);
  assign match_count  = r_count;
  assign first_pos    = r_first;
  assign last_pos     = r_last;
  assign hit_map      = r_map;

endmodule

`default_nettype wire
